pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Fetch-stage program-counter controller. Parametrised successor of the simple stalled PC register.
//  Holds PC_F and issues instruction-memory requests. Selects the next PC from exception, branch
//  redirect, parked redirect or sequential PC. Parks redirects that arrive while fetch cannot advance.
//  Supports halt/park. Sits between the hazard unit / decode redirect logic and the instruction memory.
// PARAMETERS
//  ADDR_W      32            PC / address width in bits (>= 8)
//  RESET_PC    32'h00400030  PC_F value after reset (truncated to ADDR_W)
//  EXC_VECTOR  32'h80000180  target PC on exc_valid (truncated to ADDR_W)
//  ALIGN_BITS  2             low PC bits forced to 0 (instruction size = 2**ALIGN_BITS bytes)
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  stall_f         in   1       hazard-unit stall of fetch stage
//  halt_req        in   1       park fetch after current PC (level)
//  redirect_valid  in   1       branch/jump redirect from decode
//  redirect_pc     in   ADDR_W  redirect target
//  exc_valid       in   1       exception redirect (highest priority)
//  imem_ready      in   1       instruction for imem_addr returned this cycle
//  imem_req        out  1       fetch request valid
//  imem_addr       out  ADDR_W  fetch address (== pc_f)
//  pc_f            out  ADDR_W  current fetch PC
//  pc_plus_f       out  ADDR_W  pc_f + 2**ALIGN_BITS, wraps mod 2**ADDR_W
//  fetch_valid_f   out  1       instruction at pc_f is on the correct path and accepted
//  halted          out  1       FSM in HALT
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc_f=RESET_PC, state=BOOT, pend_valid=0, pend_pc=0.
//   - imem_req=0, fetch_valid_f=0, halted=0.
//  FSM states BOOT, RUN, HALT:
//   - BOOT: one cycle, imem_req=0, no advance -> RUN unconditionally (exc/redirect in BOOT are parked).
//   - RUN: imem_req=1. adv = imem_ready & ~stall_f. If halt_req & adv & no redirect/exc/pend -> HALT
//     with pc_f <= pc_plus_f.
//   - HALT: imem_req=0, halted=1, pc_f held. exc_valid or redirect_valid -> RUN with pc_f <= target
//     next edge. halt_req ignored in HALT.
//  Next-PC priority in RUN when adv=1:
//   - exc_valid -> EXC_VECTOR; else redirect_valid -> redirect_pc; else pend_valid -> pend_pc;
//     else pc_plus_f.
//   - pend cleared on any adv. Low ALIGN_BITS of every loaded PC are forced to 0.
//  RUN with adv=0: pc_f held.
//   - exc_valid parks EXC_VECTOR (overwrites any pending).
//   - redirect_valid parks redirect_pc only if the pending entry is not an exception. pend_is_exc is
//     tracked internally.
//   - Same-cycle exc+redirect: exception wins; redirect dropped.
//  fetch_valid_f = (state==RUN) & imem_ready & ~stall_f & ~pend_valid & ~exc_valid & ~redirect_valid.
//   - Wrong-path fetch is killed combinationally; next correct instruction is 1 cycle after redirect
//     acceptance.
//  Latency:
//   - Redirect accepted at edge N -> pc_f=target after N. With imem_ready=1, first valid fetch in cycle N+1.
//   - No extra bubble beyond the killed slot.
//  Wrap: pc_plus_f of all-ones-aligned PC = 0; no flag raised.
//  Reset mid-operation: all state, including pend, is discarded immediately. Outputs take reset values
//  asynchronously.
// STRUCTURE
//  fetch_pkg:
//   - fetch_state_t enum {BOOT, RUN, HALT}.
//   - PC_INC = 1<<ALIGN_BITS.
//   - Priority encoding of redirect sources fetch_src_t {SRC_EXC, SRC_BR, SRC_PEND, SRC_SEQ}.
//  Sub-module pc_redirect_hold:
//   - Pending register (pend_valid, pend_pc, pend_is_exc) with capture/overwrite/clear rules.
//  Top level holds the FSM, next-PC mux and pc_f register.
// TESTING
//  1 Reset released, imem_ready=1 -> cycle0 BOOT imem_req=0, then pc_f=0x00400030, 0x00400034,
//    0x00400038 with fetch_valid_f=1.
//  2 stall_f=1 for 3 cycles at pc 0x00400038 -> pc_f held, fetch_valid_f=0; release -> 0x0040003C next.
//  3 redirect 0x00400100 while stall_f=1, released 2 cycles later -> fetch_valid_f=0 throughout;
//    pc_f=0x00400100 after release edge; pend cleared.
//  4 Same cycle exc_valid+redirect_valid with adv=1 -> pc_f=0x80000180.
//    Parked exc then later redirect while stalled -> exc target still used.
//  5 halt_req in RUN -> HALT, imem_req=0, halted=1, pc held; redirect 0x00400200 -> RUN,
//    pc_f=0x00400200.
//  6 ADDR_W=16, pc_f=0xFFFC, adv -> pc_f=0x0000. Assert rst_n=0 mid-stall with pending redirect ->
//    pc_f=RESET_PC, pend_valid=0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch-stage PC controller.
// Defines the FSM states, the next-PC source encoding and the instruction-size increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    typedef enum logic [1:0] {
        SRC_EXC,
        SRC_BR,
        SRC_PEND,
        SRC_SEQ
    } fetch_src_t;

    localparam int unsigned DEFAULT_ALIGN_BITS = 2;
    localparam int unsigned PC_INC             = 1 << DEFAULT_ALIGN_BITS;

    function automatic int unsigned pc_inc(input int unsigned align_bits);
        return 1 << align_bits;
    endfunction

    // Exception beats a live redirect, which beats a parked one.
    function automatic fetch_src_t select_src(input logic exc, input logic br, input logic pend);
        if (exc) begin
            return SRC_EXC;
        end else if (br) begin
            return SRC_BR;
        end else if (pend) begin
            return SRC_PEND;
        end
        return SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// Parks a redirect target that arrives while fetch cannot advance.
// A parked exception target is never replaced by a later branch redirect.
module pc_redirect_hold #(
    parameter int unsigned     ADDR_W = 32,
    parameter logic [ADDR_W-1:0] EXC_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_park,
    input  logic              i_exc_valid,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_pend_valid,
    output logic [ADDR_W-1:0] o_pend_pc
);

    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_pend_is_exc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_pc     <= '0;
            r_pend_is_exc <= 1'b0;
        end else if (i_clear) begin
            r_pend_valid  <= 1'b0;
            r_pend_is_exc <= 1'b0;
        end else if (i_park) begin
            if (i_exc_valid) begin
                r_pend_valid  <= 1'b1;
                r_pend_pc     <= EXC_PC;
                r_pend_is_exc <= 1'b1;
            end else if (i_redirect_valid && !(r_pend_valid && r_pend_is_exc)) begin
                r_pend_valid  <= 1'b1;
                r_pend_pc     <= i_redirect_pc;
                r_pend_is_exc <= 1'b0;
            end
        end
    end

    assign o_pend_valid = r_pend_valid;
    assign o_pend_pc    = r_pend_pc;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: BOOT/RUN/HALT FSM, next-PC priority mux and the pc_f register.
// Redirects that cannot be taken immediately are parked in pc_redirect_hold.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0040_0030,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall_f,
    input  logic              i_halt_req,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_exc_valid,
    input  logic              i_imem_ready,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [ADDR_W-1:0] o_pc_f,
    output logic [ADDR_W-1:0] o_pc_plus_f,
    output logic              o_fetch_valid_f,
    output logic              o_halted
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC) & ALIGN_MASK;
    localparam logic [ADDR_W-1:0] EXC_PC_A   = ADDR_W'(EXC_VECTOR) & ALIGN_MASK;
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(pc_inc(ALIGN_BITS));

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_imem_req;
    logic              r_halted;

    logic              w_adv;
    logic              w_run;
    logic              w_clear;
    logic              w_park;
    logic              w_pend_valid;
    logic [ADDR_W-1:0] w_pend_pc;
    logic [ADDR_W-1:0] w_redirect_pc_a;
    logic [ADDR_W-1:0] w_pc_plus;
    logic [ADDR_W-1:0] w_target;
    fetch_src_t        w_src;

    assign w_adv           = i_imem_ready & ~i_stall_f;
    assign w_run           = (r_state == RUN);
    assign w_clear         = w_run & w_adv;
    // BOOT never advances, so anything arriving there is parked like a stalled RUN cycle.
    assign w_park          = (r_state == BOOT) | (w_run & ~w_adv);
    assign w_redirect_pc_a = i_redirect_pc & ALIGN_MASK;
    assign w_pc_plus       = r_pc + INC;
    assign w_src           = select_src(i_exc_valid, i_redirect_valid, w_pend_valid);

    always_comb begin
        w_target = w_pc_plus;
        unique case (w_src)
            SRC_EXC:  w_target = EXC_PC_A;
            SRC_BR:   w_target = w_redirect_pc_a;
            SRC_PEND: w_target = w_pend_pc;
            SRC_SEQ:  w_target = w_pc_plus;
            default:  w_target = w_pc_plus;
        endcase
    end

    pc_redirect_hold #(
        .ADDR_W (ADDR_W),
        .EXC_PC (EXC_PC_A)
    ) u_hold (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_clear          (w_clear),
        .i_park           (w_park),
        .i_exc_valid      (i_exc_valid),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (w_redirect_pc_a),
        .o_pend_valid     (w_pend_valid),
        .o_pend_pc        (w_pend_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC_A;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_imem_req <= 1'b1;
                end
                RUN: begin
                    if (w_adv) begin
                        r_pc <= w_target;
                        // Halt only on a clean sequential step so no redirect is lost.
                        if (i_halt_req && (w_src == SRC_SEQ)) begin
                            r_state    <= HALT;
                            r_imem_req <= 1'b0;
                            r_halted   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (i_exc_valid || i_redirect_valid) begin
                        r_pc       <= w_target;
                        r_state    <= RUN;
                        r_imem_req <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_imem_req <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req      = r_imem_req;
    assign o_imem_addr     = r_pc;
    assign o_pc_f          = r_pc;
    assign o_pc_plus_f     = w_pc_plus;
    assign o_halted        = r_halted;
    assign o_fetch_valid_f = w_run & w_adv & ~w_pend_valid & ~i_exc_valid & ~i_redirect_valid;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a 32-bit instance for the main flow and a 16-bit
// instance for wrap-around, alignment and mid-operation reset.
module tb_pc_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 32-bit instance
    logic        rst_n, stall, halt, rv, exc, ready;
    logic [31:0] rpc;
    logic        req, fv, halted;
    logic [31:0] addr, pc, pcp;

    pc_fetch_ctrl #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0040_0030),
        .EXC_VECTOR (32'h8000_0180),
        .ALIGN_BITS (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall_f        (stall),
        .i_halt_req       (halt),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_exc_valid      (exc),
        .i_imem_ready     (ready),
        .o_imem_req       (req),
        .o_imem_addr      (addr),
        .o_pc_f           (pc),
        .o_pc_plus_f      (pcp),
        .o_fetch_valid_f  (fv),
        .o_halted         (halted)
    );

    // 16-bit instance
    logic        rst16_n, stall16, halt16, rv16, exc16, ready16;
    logic [15:0] rpc16;
    logic        req16, fv16, halted16;
    logic [15:0] addr16, pc16, pcp16;

    pc_fetch_ctrl #(
        .ADDR_W     (16),
        .RESET_PC   (32'h0040_0030),
        .EXC_VECTOR (32'h8000_0180),
        .ALIGN_BITS (2)
    ) dut16 (
        .i_clk            (clk),
        .i_rst_n          (rst16_n),
        .i_stall_f        (stall16),
        .i_halt_req       (halt16),
        .i_redirect_valid (rv16),
        .i_redirect_pc    (rpc16),
        .i_exc_valid      (exc16),
        .i_imem_ready     (ready16),
        .o_imem_req       (req16),
        .o_imem_addr      (addr16),
        .o_pc_f           (pc16),
        .o_pc_plus_f      (pcp16),
        .o_fetch_valid_f  (fv16),
        .o_halted         (halted16)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; rv = 1'b0; exc = 1'b0; ready = 1'b1;
        rpc = '0;
        rst16_n = 1'b0; stall16 = 1'b0; halt16 = 1'b0; rv16 = 1'b0; exc16 = 1'b0;
        ready16 = 1'b1; rpc16 = '0;

        // Reset values
        #12;
        check("rst_pc", pc, 32'h0040_0030);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_fv", {31'b0, fv}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);

        // 1: boot then sequential fetch
        tick();
        rst_n = 1'b1;
        #1;
        check("boot_req", {31'b0, req}, 32'd0);
        check("boot_fv", {31'b0, fv}, 32'd0);
        tick();
        check("run0_pc", pc, 32'h0040_0030);
        check("run0_req", {31'b0, req}, 32'd1);
        check("run0_fv", {31'b0, fv}, 32'd1);
        check("run0_plus", pcp, 32'h0040_0034);
        tick();
        check("run1_pc", pc, 32'h0040_0034);
        check("run1_addr", addr, 32'h0040_0034);
        tick();
        check("run2_pc", pc, 32'h0040_0038);
        check("run2_fv", {31'b0, fv}, 32'd1);

        // 2: stall holds pc for three cycles
        stall = 1'b1;
        #1;
        check("stall_fv", {31'b0, fv}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 32'h0040_0038);
        end
        stall = 1'b0;
        #1;
        check("unstall_fv", {31'b0, fv}, 32'd1);
        tick();
        check("unstall_pc", pc, 32'h0040_003C);

        // 3: redirect parked during stall
        stall = 1'b1; rv = 1'b1; rpc = 32'h0040_0100;
        #1;
        check("park_fv0", {31'b0, fv}, 32'd0);
        tick();
        rv = 1'b0;
        #1;
        check("park_pc0", pc, 32'h0040_003C);
        check("park_fv1", {31'b0, fv}, 32'd0);
        tick();
        stall = 1'b0;
        #1;
        check("park_pc1", pc, 32'h0040_003C);
        check("park_fv2", {31'b0, fv}, 32'd0);
        tick();
        check("park_taken_pc", pc, 32'h0040_0100);
        check("park_cleared_fv", {31'b0, fv}, 32'd1);

        // 4a: exception beats same-cycle redirect
        exc = 1'b1; rv = 1'b1; rpc = 32'h0040_0300;
        #1;
        check("exc_kill_fv", {31'b0, fv}, 32'd0);
        tick();
        exc = 1'b0; rv = 1'b0;
        #1;
        check("exc_pc", pc, 32'h8000_0180);
        check("exc_fv", {31'b0, fv}, 32'd1);
        tick();
        check("exc_seq_pc", pc, 32'h8000_0184);

        // 4b: parked exception is not overwritten by a later redirect
        stall = 1'b1; exc = 1'b1;
        tick();
        exc = 1'b0; rv = 1'b1; rpc = 32'h0040_0400;
        tick();
        rv = 1'b0; stall = 1'b0;
        #1;
        check("pexc_fv", {31'b0, fv}, 32'd0);
        check("pexc_hold_pc", pc, 32'h8000_0184);
        tick();
        check("pexc_pc", pc, 32'h8000_0180);

        // 5: halt and wake by redirect
        halt = 1'b1;
        #1;
        check("halt_req_fv", {31'b0, fv}, 32'd1);
        tick();
        check("halt_pc", pc, 32'h8000_0184);
        check("halt_halted", {31'b0, halted}, 32'd1);
        check("halt_req", {31'b0, req}, 32'd0);
        check("halt_fv", {31'b0, fv}, 32'd0);
        tick();
        check("halt_hold_pc", pc, 32'h8000_0184);
        halt = 1'b0; rv = 1'b1; rpc = 32'h0040_0200;
        #1;
        check("halt_rv_fv", {31'b0, fv}, 32'd0);
        tick();
        rv = 1'b0;
        #1;
        check("wake_pc", pc, 32'h0040_0200);
        check("wake_halted", {31'b0, halted}, 32'd0);
        check("wake_req", {31'b0, req}, 32'd1);
        check("wake_fv", {31'b0, fv}, 32'd1);

        // 6: 16-bit wrap, alignment, reset with a parked redirect
        rst16_n = 1'b1;
        #1;
        check("w16_boot_req", {31'b0, req16}, 32'd0);
        check("w16_boot_pc", {16'b0, pc16}, 32'h0000_0030);
        tick();
        check("w16_run_pc", {16'b0, pc16}, 32'h0000_0030);
        rv16 = 1'b1; rpc16 = 16'hFFFE;
        #1;
        check("w16_rv_fv", {31'b0, fv16}, 32'd0);
        tick();
        rv16 = 1'b0;
        #1;
        check("w16_align_pc", {16'b0, pc16}, 32'h0000_FFFC);
        check("w16_plus_wrap", {16'b0, pcp16}, 32'h0000_0000);
        check("w16_fv", {31'b0, fv16}, 32'd1);
        tick();
        check("w16_wrap_pc", {16'b0, pc16}, 32'h0000_0000);
        stall16 = 1'b1; rv16 = 1'b1; rpc16 = 16'h1234;
        tick();
        rv16 = 1'b0;
        #1;
        rst16_n = 1'b0;
        #1;
        check("w16_arst_pc", {16'b0, pc16}, 32'h0000_0030);
        check("w16_arst_req", {31'b0, req16}, 32'd0);
        check("w16_arst_fv", {31'b0, fv16}, 32'd0);
        stall16 = 1'b0;
        tick();
        rst16_n = 1'b1;
        tick();
        check("w16_rerun_pc", {16'b0, pc16}, 32'h0000_0030);
        check("w16_rerun_fv", {31'b0, fv16}, 32'd1);
        tick();
        check("w16_nopend_pc", {16'b0, pc16}, 32'h0000_0034);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
